// File: rtl/data_memory_lsu.sv
// Word-organised data memory with RISC-V load/store lane handling and a clear-on-reset sweep.
// Latency: stores commit at the sampling edge; load data, read_valid and fault flags are registered, 1 cycle.
// Backpressure: ready is low during the clear sweep, and requests made then are dropped without side effects.
module data_memory_lsu #(
  parameter int DEPTH_BYTES    = 512,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        ready,
  output logic        misaligned,
  output logic        access_fault
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int IW    = AW - 2;
  localparam int WORDS = DEPTH_BYTES / 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] clear_ptr;
  logic [IW-1:0] clear_ptr_nxt;
  logic          clear_we;

  logic [31:0]   mem [WORDS];

  logic [1:0]    lane;
  logic [IW-1:0] word_idx;
  logic          req;
  logic          f3_illegal;
  logic          out_of_range;
  logic          unaligned;
  logic          flag_fault;
  logic          flag_mis;
  logic          access_ok;
  logic          do_store;
  logic          do_load;
  logic [3:0]    store_strb;
  logic [31:0]   store_wdat;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_ext;

  // State register; reset restarts the sweep from word 0 (or skips it).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clear_ptr <= '0;
    end else begin
      state     <= state_nxt;
      clear_ptr <= clear_ptr_nxt;
    end
  end

  // Next state: sweep one word per cycle, move to READY after the last word.
  always_comb begin
    state_nxt     = state;
    clear_ptr_nxt = clear_ptr;
    clear_we      = 1'b0;
    case (state)
      ST_CLEAR: begin
        clear_we      = 1'b1;
        clear_ptr_nxt = clear_ptr + IW'(1);
        if (clear_ptr == IW'(WORDS - 1)) begin
          state_nxt = ST_READY;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  assign ready    = (state == ST_READY);
  assign lane     = address[1:0];
  assign word_idx = address[AW-1:2];

  // Request qualification and fault priority: illegal funct3, then range, then alignment.
  always_comb begin
    req          = (write_enable | read_enable) & ready;
    // 100/101 are load-only encodings, so any store (including a combined
    // load+store) with them is illegal and suppresses both halves.
    f3_illegal   = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) |
                   (write_enable & funct3[2]);
    out_of_range = (address >= 32'(DEPTH_BYTES));
    unaligned    = ((funct3[1:0] == 2'b01) & lane[0]) |
                   ((funct3[1:0] == 2'b10) & (lane != 2'b00));
    flag_fault   = req & (f3_illegal | out_of_range);
    flag_mis     = req & ~f3_illegal & ~out_of_range & unaligned;
    access_ok    = req & ~f3_illegal & ~out_of_range & ~unaligned;
    do_store     = access_ok & write_enable;
    do_load      = access_ok & read_enable;
  end

  // Store lane strobes and data replicated onto every lane the size can hit.
  always_comb begin
    store_strb = 4'b1111;
    store_wdat = write_data;
    case (funct3[1:0])
      2'b00: begin
        store_strb = 4'b0001 << lane;
        store_wdat = {4{write_data[7:0]}};
      end
      2'b01: begin
        store_strb = lane[1] ? 4'b1100 : 4'b0011;
        store_wdat = {2{write_data[15:0]}};
      end
      default: begin
        store_strb = 4'b1111;
        store_wdat = write_data;
      end
    endcase
  end

  // Single write port: the sweep and stores never overlap since stores need READY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_we) begin
        mem[clear_ptr] <= '0;
      end else if (do_store) begin
        for (int i = 0; i < 4; i++) begin
          if (store_strb[i]) begin
            mem[word_idx][8*i +: 8] <= store_wdat[8*i +: 8];
          end
        end
      end
    end
  end

  // Load lane select and sign/zero extension from the current (pre-store) word.
  always_comb begin
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext = rd_word;
    case (funct3)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  // Registered response; read_data holds between loads, pulses clear each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data    <= '0;
      read_valid   <= 1'b0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      read_valid   <= do_load;
      misaligned   <= flag_mis;
      access_fault <= flag_fault;
      if (do_load) begin
        read_data <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu with a scoreboard of expected responses.
// Stimulus pushes the expected response and due cycle; a negedge monitor pops and compares.
// Missing, late or unexpected responses are all reported as failures.
module tb_data_memory_lsu;

  localparam int K_RD  = 1;
  localparam int K_MIS = 2;
  localparam int K_FLT = 3;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [2:0]  funct3;
  logic [31:0] read_data;
  logic        read_valid;
  logic        ready;
  logic        misaligned;
  logic        access_fault;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_cnt;

  data_memory_lsu #(.DEPTH_BYTES(512), .CLEAR_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .funct3       (funct3),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .ready        (ready),
    .misaligned   (misaligned),
    .access_fault (access_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every output pulse must match the scoreboard head in kind, data and cycle.
  always @(negedge clk) begin
    if (read_valid || misaligned || access_fault) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: rv=%0b mis=%0b af=%0b data=%h, required no output",
                 read_valid, misaligned, access_fault, read_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({read_valid, misaligned, access_fault} !=
              {mon_e.kind == K_RD, mon_e.kind == K_MIS, mon_e.kind == K_FLT} ||
            (mon_e.kind == K_RD && read_data != mon_e.data) || cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL response: got rv=%0b mis=%0b af=%0b data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                   read_valid, misaligned, access_fault, read_data, cyc,
                   mon_e.kind, mon_e.data, mon_e.due);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      n_checks++;
      n_fail++;
      mon_e = exp_q.pop_front();
      $display("FAIL missing_output: got none at cyc=%0d, required kind=%0d data=%h",
               cyc, mon_e.kind, mon_e.data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one request for one cycle; kind 0 means no response is expected.
  task automatic drv(input logic w, input logic r, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, input int kind, input logic [31:0] ed);
    exp_t e;
    @(posedge clk);
    #1;
    write_enable = w;
    read_enable  = r;
    funct3       = f;
    address      = a;
    write_data   = wd;
    if (kind != 0) begin
      e.kind = kind;
      e.data = ed;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      read_enable  = 1'b0;
    end
  endtask

  // Count negedges with ready low after a reset release, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!ready && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset        = 1'b1;
    address      = '0;
    write_data   = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    funct3       = 3'b010;

    @(negedge clk);
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_flags", {28'h0, read_valid, ready, misaligned, access_fault}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(rdy_cnt);
    chk("sweep_length", 32'(rdy_cnt), 32'd128);

    // Every word reads back zero after the sweep.
    for (int i = 0; i < 128; i++) begin
      drv(1'b0, 1'b1, 3'b010, 32'(i * 4), 32'h0, K_RD, 32'h0);
    end

    // Word store and sub-word loads.
    drv(1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, K_RD, 32'hDEADBEEF);
    drv(1'b0, 1'b1, 3'b101, 32'h12, 32'h0, K_RD, 32'h0000DEAD);
    drv(1'b0, 1'b1, 3'b000, 32'h10, 32'h0, K_RD, 32'hFFFFFFEF);

    // Byte store at the top lane.
    drv(1'b1, 1'b0, 3'b000, 32'h23, 32'h00000080, 0, 32'h0);
    drv(1'b0, 1'b1, 3'b000, 32'h23, 32'h0, K_RD, 32'hFFFFFF80);
    drv(1'b0, 1'b1, 3'b100, 32'h23, 32'h0, K_RD, 32'h00000080);
    drv(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, K_RD, 32'h80000000);
    drv(1'b0, 1'b1, 3'b001, 32'h22, 32'h0, K_RD, 32'hFFFF8000);

    // Misalignment.
    drv(1'b1, 1'b0, 3'b010, 32'h04, 32'h11223344, 0, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h06, 32'h0, K_MIS, 32'h0);
    drv(1'b1, 1'b0, 3'b001, 32'h05, 32'h0000FFFF, K_MIS, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h04, 32'h0, K_RD, 32'h11223344);
    drv(1'b0, 1'b1, 3'b001, 32'h06, 32'h0, K_RD, 32'h00001122);
    drv(1'b0, 1'b1, 3'b101, 32'h04, 32'h0, K_RD, 32'h00003344);
    drv(1'b0, 1'b1, 3'b000, 32'h07, 32'h0, K_RD, 32'h00000011);

    // Access faults, including priority over misalignment.
    drv(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, K_FLT, 32'h0);
    drv(1'b0, 1'b1, 3'b011, 32'h04, 32'h0, K_FLT, 32'h0);
    drv(1'b1, 1'b0, 3'b100, 32'h04, 32'h000000FF, K_FLT, 32'h0);
    drv(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, K_FLT, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h201, 32'h0, K_FLT, 32'h0);
    drv(1'b0, 1'b1, 3'b111, 32'h05, 32'h0, K_FLT, 32'h0);
    drv(1'b0, 1'b1, 3'b110, 32'h04, 32'h0, K_FLT, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h04, 32'h0, K_RD, 32'h11223344);

    // Highest in-range word.
    drv(1'b1, 1'b0, 3'b010, 32'h1FC, 32'hCAFEF00D, 0, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h1FC, 32'h0, K_RD, 32'hCAFEF00D);

    // Simultaneous load+store returns the old word.
    drv(1'b1, 1'b0, 3'b010, 32'h40, 32'hAAAAAAAA, 0, 32'h0);
    drv(1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678, K_RD, 32'hAAAAAAAA);
    drv(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, K_RD, 32'h12345678);
    drv(1'b1, 1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, K_FLT, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, K_RD, 32'h12345678);
    idle(3);

    // Reset in READY together with a load: the load must not respond.
    @(posedge clk);
    #1;
    reset       = 1'b1;
    read_enable = 1'b1;
    funct3      = 3'b010;
    address     = 32'h10;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    read_enable = 1'b0;
    @(negedge clk);
    chk("abort_read_valid", {31'h0, read_valid}, 32'h0);

    // Requests during the sweep are ignored; reset at sweep cycle 50 restarts it.
    for (int i = 0; i < 49; i++) begin
      drv(1'b1, 1'b1, 3'b010, 32'h40, 32'hFFFFFFFF, 0, 32'h0);
    end
    @(posedge clk);
    #1;
    reset        = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(rdy_cnt);
    chk("sweep_restart_length", 32'(rdy_cnt), 32'd128);
    drv(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, K_RD, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, K_RD, 32'h0);
    drv(1'b0, 1'b1, 3'b010, 32'h1FC, 32'h0, K_RD, 32'h0);
    idle(4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
